// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry for the direct-mapped data cache
package dcache_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam int OFFSET_W   = 5;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    localparam int LINE_BYTES = LINE_W / 8;

    function automatic int tag_width(input int s_index);
        return 32 - OFFSET_W - s_index;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - CPU dmem port and physical-memory line port of the data cache
interface dcache_if;

    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;

    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - per-set valid/dirty/tag/line storage with byte-enable line writes
module dcache_array
    import dcache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [S_INDEX-1:0]    index,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag,
    output logic [LINE_W-1:0]     line,
    input  logic                  meta_we,
    input  logic                  meta_valid,
    input  logic                  meta_dirty,
    input  logic [TAG_W-1:0]      meta_tag,
    input  logic [LINE_BYTES-1:0] line_be,
    input  logic [LINE_W-1:0]     line_wdata
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[index] <= meta_valid;
            dirty_q[index] <= meta_dirty;
        end
    end

    // Tags and data need no reset: a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (meta_we)
            tag_q[index] <= meta_tag;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (line_be[b])
                line_q[index][b*8 +: 8] <= line_wdata[b*8 +: 8];
        end
    end

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign line  = line_q[index];

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back write-allocate data cache with single-outstanding line port
module dcache
    import dcache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);

    localparam int TAG_W = tag_width(S_INDEX);

    state_t state, next_state;

    logic [S_INDEX-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic [2:0]            word;
    logic                  req;
    logic                  hit;

    logic                  arr_valid;
    logic                  arr_dirty;
    logic [TAG_W-1:0]      arr_tag;
    logic [LINE_W-1:0]     arr_line;
    logic                  meta_we;
    logic                  meta_valid;
    logic                  meta_dirty;
    logic [TAG_W-1:0]      meta_tag;
    logic [LINE_BYTES-1:0] line_be;
    logic [LINE_W-1:0]     line_wdata;
    logic [LINE_BYTES-1:0] word_be;

    logic                  mem_resp;
    logic [31:0]           mem_rdata;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [LINE_W-1:0]     pmem_wdata;

    assign index   = bus.mem_address[OFFSET_W +: S_INDEX];
    assign tag     = bus.mem_address[31 -: TAG_W];
    assign word    = bus.mem_address[4:2];
    assign req     = bus.mem_read | bus.mem_write;
    assign hit     = arr_valid && (arr_tag == tag);
    assign word_be = {{(LINE_BYTES-4){1'b0}}, bus.mem_byte_enable} << {word, 2'b00};

    dcache_array #(
        .S_INDEX (S_INDEX),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .valid      (arr_valid),
        .dirty      (arr_dirty),
        .tag        (arr_tag),
        .line       (arr_line),
        .meta_we    (meta_we),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty),
        .meta_tag   (meta_tag),
        .line_be    (line_be),
        .line_wdata (line_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        meta_we      = 1'b0;
        meta_valid   = 1'b0;
        meta_dirty   = 1'b0;
        meta_tag     = tag;
        line_be      = '0;
        line_wdata   = {(LINE_W/WORD_W){bus.mem_wdata}};

        unique case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = arr_line[{word, 5'b00000} +: WORD_W];
                        if (bus.mem_write) begin
                            line_be = word_be;
                            // An all-zero byte enable leaves the line clean.
                            if (|bus.mem_byte_enable) begin
                                meta_we    = 1'b1;
                                meta_valid = 1'b1;
                                meta_dirty = 1'b1;
                            end
                        end
                    end else if (arr_valid && arr_dirty) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {arr_tag, index, {OFFSET_W{1'b0}}};
                pmem_wdata   = arr_line;
                if (bus.pmem_resp) begin
                    meta_we    = 1'b1;
                    meta_valid = 1'b1;
                    meta_dirty = 1'b0;
                    meta_tag   = arr_tag;
                    next_state = FILL;
                end
            end

            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {bus.mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                if (bus.pmem_resp) begin
                    line_be    = '1;
                    line_wdata = bus.pmem_rdata;
                    meta_we    = 1'b1;
                    meta_valid = 1'b1;
                    meta_dirty = 1'b0;
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    assign bus.mem_resp     = mem_resp;
    assign bus.mem_rdata    = mem_rdata;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_write   = pmem_write;
    assign bus.pmem_address = pmem_address;
    assign bus.pmem_wdata   = pmem_wdata;

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed plus randomized checking of dcache against a line-level reference model
module tb_dcache;

    localparam int S_INDEX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_if bus();

    dcache #(.S_INDEX(S_INDEX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: cache contents per set and a sparse main memory.
    bit           mv [8];
    bit           md [8];
    logic [23:0]  mt [8];
    logic [255:0] ml [8];
    logic [255:0] mem [logic [26:0]];

    int checks = 0;
    int passed = 0;
    logic [31:0]  last_rdata;
    logic [255:0] last_wb;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] get_mem(input logic [26:0] la);
        if (!mem.exists(la)) mem[la] = rand_line();
        return mem[la];
    endfunction

    task automatic pmem_phase(input bit is_wb, input int lat, input logic [31:0] exp_addr,
                              input logic [255:0] line, input string name);
        bit ok = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            bus.pmem_resp  = (k == lat);
            bus.pmem_rdata = is_wb ? '0 : line;
            @(negedge clk);
            if ({bus.mem_resp, bus.pmem_read, bus.pmem_write} !== {1'b0, !is_wb, is_wb}) ok = 1'b0;
            if (k == 1) begin
                check({name, is_wb ? "_wb_addr" : "_fill_addr"}, bus.pmem_address, exp_addr);
                if (is_wb) begin
                    last_wb = bus.pmem_wdata;
                    check({name, "_wb_data"}, bus.pmem_wdata, line);
                end
            end
        end
        check({name, is_wb ? "_wb_strobes" : "_fill_strobes"}, ok, 1'b1);
    endtask

    // Called and returns at posedge+1; follows the cache's observable protocol step by step.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int wb_lat, input int fill_lat, input string name);
        logic [2:0]  idx;
        logic [23:0] tg;
        int          wi;
        bit          hit;
        logic [31:0] exp_rd;
        idx = addr[7:5];
        tg  = addr[31:8];
        wi  = int'(addr[4:2]);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        hit = mv[idx] && (mt[idx] == tg);
        if (!hit) begin
            @(negedge clk);
            check({name, "_miss_c0"}, {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_address}, '0);
            if (mv[idx] && md[idx]) begin
                pmem_phase(1'b1, wb_lat, {mt[idx], idx, 5'b0}, ml[idx], name);
                mem[{mt[idx], idx}] = ml[idx];
                md[idx] = 1'b0;
            end
            ml[idx] = get_mem(addr[31:5]);
            pmem_phase(1'b0, fill_lat, {addr[31:5], 5'b0}, ml[idx], name);
            mv[idx] = 1'b1;
            mt[idx] = tg;
            @(posedge clk); #1;
            bus.pmem_resp = 1'b0;
        end
        @(negedge clk);
        exp_rd     = ml[idx][wi*32 +: 32];
        last_rdata = bus.mem_rdata;
        check({name, "_resp"}, {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_address}, {3'b100, 32'h0});
        check({name, "_rdata"}, bus.mem_rdata, exp_rd);
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ml[idx][wi*32 + b*8 +: 8] = wd[b*8 +: 8];
            if (be != 4'b0) md[idx] = 1'b1;
        end
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        bit           r, w;
        rst = 1'b1;
        bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.mem_byte_enable = '0;
        bus.mem_address = '0; bus.mem_wdata = '0;    bus.pmem_rdata = '0;  bus.pmem_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; ml[i] = '0; end
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.mem_rdata,
                                bus.pmem_address, bus.pmem_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        l = rand_line();
        l[95:64] = 32'hDEADBEEF;
        mem[27'h2] = l;

        access(1, 0, 32'h40, 4'h0, 32'h0, 1, 3, "fill40");
        access(1, 0, 32'h48, 4'h0, 32'h0, 1, 1, "rd48");
        check("rd48_const", last_rdata, 32'hDEADBEEF);
        access(0, 1, 32'h48, 4'b0011, 32'h11223344, 1, 1, "wr48");
        access(1, 0, 32'h48, 4'h0, 32'h0, 1, 1, "rd48b");
        check("rd48b_const", last_rdata, 32'hDEAD3344);
        access(1, 0, 32'h440, 4'h0, 32'h0, 2, 2, "evict440");
        check("wb_word2", last_wb[95:64], 32'hDEAD3344);
        access(1, 1, 32'h444, 4'b1111, 32'hCAFEF00D, 1, 1, "rw_hit");
        access(1, 0, 32'h444, 4'h0, 32'h0, 1, 1, "rw_rd");
        check("rw_const", last_rdata, 32'hCAFEF00D);
        access(1, 0, 32'h40, 4'h0, 32'h0, 1, 1, "rw_evict");

        // Ignored pmem_resp while idle.
        @(posedge clk); #1; bus.pmem_resp = 1'b1;
        @(negedge clk);
        check("idle_pmem_resp", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
        @(posedge clk); #1; bus.pmem_resp = 1'b0;

        // Reset in the middle of a fill.
        bus.mem_read = 1'b1; bus.mem_address = 32'hA0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("fill_before_rst", bus.pmem_read, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_drops_strobes", {bus.pmem_read, bus.pmem_write, bus.mem_resp}, 3'b000);
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; end
        access(1, 0, 32'hA0, 4'h0, 32'h0, 1, 2, "after_rst");

        access(0, 1, 32'hA4, 4'b0000, 32'h55555555, 1, 1, "be0_write");
        access(1, 0, 32'h1A0, 4'h0, 32'h0, 1, 1, "be0_evict");

        for (int n = 0; n < 200; n++) begin
            a = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom), 2'b00};
            r = $urandom_range(0, 1);
            w = ($urandom_range(0, 2) == 0) ? 1'b1 : !r;
            access(r, w, a, ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom), $urandom,
                   $urandom_range(1, 4), $urandom_range(1, 4), "rand");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache answering the CPU's dmem request port (read/write, byte enable, address, wdata in; resp, rdata out). It is the responder end of that port. It fills and evicts 256-bit lines over a single-outstanding physical-memory port. It sits between the CPU and the main-memory arbiter.

## Interface
- S_INDEX, default 3: index bits (2^S_INDEX sets); offset fixed at 5 bits; tag = 27 − S_INDEX bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp; wins if asserted with mem_read.
- mem_byte_enable  in  4  write byte lanes of the addressed word.
- mem_address  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  32  addressed word, valid when mem_resp.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address, bits [4:0] = 0.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line, sampled when pmem_resp.
- pmem_resp  in  1  one-cycle completion of pmem_read/pmem_write.

## Operation
- Per set: valid, dirty, tag, 256-bit line. Word select = mem_address[4:2].
- States: IDLE, WRITEBACK, FILL.
- IDLE, request, hit (valid & tag match):
  - mem_resp=1 combinationally this cycle; mem_rdata = selected word.
  - Write hit: merge mem_wdata lanes where byte_enable=1 into the line at the clock edge.
  - Dirty set only if byte_enable≠0.
  - Stay IDLE.
- IDLE, request, miss:
  - Victim dirty → WRITEBACK.
  - Otherwise → FILL.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_address = {victim tag, index, 5'b0}, pmem_wdata = victim line.
  - On pmem_resp: dirty cleared → FILL.
- FILL:
  - pmem_read=1, pmem_address = {mem_address[31:5], 5'b0}.
  - On pmem_resp: line = pmem_rdata, tag written, valid=1, dirty=0 → IDLE.
- After FILL, the retained request hits in IDLE on the next cycle and completes by the hit rules above.
- No request in IDLE: all outputs 0; arrays unchanged.
- pmem_read and pmem_write are never asserted together.

## Timing
- Reset (async): state IDLE; all valid and dirty bits 0; mem_resp, pmem_read, pmem_write = 0. Tags and data are don't-care.
- mem_rdata, pmem_wdata and pmem_address are 0 whenever not qualified.
- Hit latency: 0 cycles (resp in the request's first IDLE cycle).
- Clean miss:
  - Request seen in cycle 0.
  - pmem_read from cycle 1 through the pmem_resp cycle N.
  - mem_resp in cycle N+1.
- Dirty miss: the writeback phase precedes the fill phase, with no idle cycle between pmem_resp of the writeback and pmem_read of the fill.
- pmem_resp arriving in the first cycle of pmem_read/pmem_write is legal (minimum 1-cycle memory).
- pmem_resp while in IDLE is ignored.
- Reset mid-WRITEBACK/FILL: the transaction is abandoned, pmem strobes drop immediately, and the set is left invalid.
- The CPU must not change its request before mem_resp; behaviour otherwise is undefined.

## Structure
- Package dcache_types:
  - state enum (IDLE, WRITEBACK, FILL).
  - Widths: offset, index and tag widths derived from S_INDEX.
  - Line width 256.
- Sub-module dcache_array:
  - Per-set storage for valid, dirty, tag and line.
  - Async reset clears valid and dirty.
  - 32-bit byte-enable write port on the line.
- dcache top holds the FSM, hit compare, word select/merge and pmem muxing.

## Test plan
- Read 0x00000040 after reset → FILL with pmem_address 0x00000040. pmem_resp after 3 cycles with word2=0xDEADBEEF → mem_rdata 0xDEADBEEF when reading 0x48, mem_resp 1 cycle after pmem_resp.
- Write 0x11223344 to 0x48, byte_enable 4'b0011 → resp same cycle; re-read 0x48 returns 0xDEAD3344 with 0-cycle latency.
- Read 0x00000440 (same index, S_INDEX=3), set dirty:
  - pmem_write at 0x40 with the word-2 field = 0xDEAD3344.
  - Then pmem_read at 0x440.
  - Then mem_resp.
- Simultaneous mem_read and mem_write on a hit → treated as write; data merged, dirty set.
- Assert rst during FILL → pmem_read falls immediately; the next read of the same address misses and issues a fresh FILL.
- Write with byte_enable 0 on a clean hit → resp; a later conflicting miss issues no writeback.
